// File: rtl/qar_uart_rx.sv
// qar_uart_rx: serial receive front-end for the QAR UART.
//
// Synchronises the asynchronous rx pin, validates start bits at half a bit
// period, samples 8N1 frames at mid-bit and hands each byte over a
// valid/ready handshake. Framing errors and overruns are reported as
// single-cycle pulses. One bit period is baud_div+1 clocks.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idle high
//   enable     receiver enable; low aborts any frame in flight
//   baud_div   bit period minus one, in clocks
//   data_out   received byte, stable while data_valid
//   data_valid byte available
//   data_ready consumer accepts the byte this cycle
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, output still occupied
//   busy       high whenever the receiver is not idle
module qar_uart_rx #(
    parameter int unsigned SYNC_STAGES = 2  // minimum 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        enable,
    input  logic [31:0] baud_div,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic        bit_tick;
    logic        half_tick;
    logic        deliver;

    // >= rather than == so that shrinking baud_div mid-frame still ticks.
    assign bit_tick  = (cnt_q >= baud_div);
    assign half_tick = (cnt_q >= (baud_div >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (half_tick) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // Line back high at mid start bit: a glitch, drop it silently.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StData: begin
                if (bit_tick) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StStop: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StWaitIdle: begin
                // Hold here through a break so it reports only one frame_err.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Disable aborts the frame with no side effects; the output holding
        // register is left alone.
        if (!enable) begin
            state_d     = StIdle;
            cnt_d       = '0;
            idx_d       = '0;
            frame_err_d = 1'b0;
            deliver     = 1'b0;
        end

        // Output holding register and handshake.
        if (deliver) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_qar_uart_rx.sv
module tb_qar_uart_rx;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        enable;
    logic [31:0] baud_div;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    qar_uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .enable    (enable),
        .baud_div  (baud_div),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int deliv_cyc = -1000;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(8);
        end
        rx = 1'b1;
        wait_cyc(8);
    endtask

    // Monitor: a new byte is presented when data_valid is high and the slot
    // was either empty or accepted at the previous edge.
    initial begin
        logic pv;
        logic pa;
        logic [7:0] e;
        pv = 1'b0;
        pa = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pa = 1'b0;
            end else begin
                if (data_valid && (!pv || pa)) begin
                    deliv_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h, expected none", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", {24'd0, data_out}, {24'd0, e});
                    end
                end
                if (frame_err) fe_cnt++;
                if (overrun) ov_cnt++;
                pv = data_valid;
                pa = data_valid && data_ready;
            end
        end
    end

    initial begin
        int fall_cyc;
        int busy_cnt;
        int fe0;
        int ov0;
        rst_n      = 1'b1;
        rx         = 1'b1;
        enable     = 1'b1;
        baud_div   = 32'd7;
        data_ready = 1'b0;
        #2 rst_n = 1'b0;
        wait_cyc(2);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(4);

        // 1: single frame, latency and handshake
        exp_q.push_back(8'hA5);
        fall_cyc = cyc;
        send_byte(8'hA5);
        wait_cyc(10);
        check("a5_latency_ok", {31'd0, (deliv_cyc - fall_cyc >= 76) && (deliv_cyc - fall_cyc <= 80)},
              32'd1);
        check("a5_valid_held", {31'd0, data_valid}, 32'd1);
        check("a5_data_out", {24'd0, data_out}, 32'hA5);
        data_ready = 1'b1;
        wait_cyc(1);
        data_ready = 1'b0;
        check("a5_valid_cleared", {31'd0, data_valid}, 32'd0);

        // 2: start-bit glitch
        busy_cnt = 0;
        rx = 1'b0;
        wait_cyc(2);
        rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            wait_cyc(1);
        end
        check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        check("glitch_busy_le6", {31'd0, busy_cnt <= 6}, 32'd1);
        check("glitch_idle", {31'd0, busy}, 32'd0);

        // 3: break then a good frame
        fe0 = fe_cnt;
        rx = 1'b0;
        wait_cyc(96);
        rx = 1'b1;
        wait_cyc(16);
        check("break_one_frame_err", fe_cnt - fe0, 32'd1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        wait_cyc(10);
        data_ready = 1'b1;
        wait_cyc(1);
        data_ready = 1'b0;

        // 4: overrun
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        send_byte(8'h22);
        wait_cyc(10);
        check("ovr_data_kept", {24'd0, data_out}, 32'h11);
        check("ovr_one_pulse", ov_cnt - ov0, 32'd1);
        data_ready = 1'b1;
        wait_cyc(1);
        data_ready = 1'b0;
        check("ovr_valid_cleared", {31'd0, data_valid}, 32'd0);

        // 5: back-to-back frames, consumer always ready
        data_ready = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hFF);
        send_byte(8'h55);
        send_byte(8'hFF);
        wait_cyc(10);
        data_ready = 1'b0;

        // 6a: reset during data bit 4
        rx = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            wait_cyc(8);
        end
        rx = 1'b1;
        wait_cyc(4);
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_out", {24'd0, data_out}, 32'h00);
        check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(20);
        exp_q.push_back(8'h81);
        send_byte(8'h81);
        wait_cyc(10);
        check("post_rst_data_out", {24'd0, data_out}, 32'h81);
        data_ready = 1'b1;
        wait_cyc(1);
        data_ready = 1'b0;

        // 6b: enable dropped mid-frame
        rx = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            wait_cyc(8);
        end
        check("en_busy_before", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        wait_cyc(1);
        check("en_abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            rx = ~i[0];
            wait_cyc(8);
        end
        rx = 1'b1;
        wait_cyc(20);
        enable = 1'b1;
        wait_cyc(20);

        check("total_frame_err", fe_cnt, 32'd1);
        check("total_overrun", ov_cnt, 32'd1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/qar_uart_rx.md
Name: qar_uart_rx

Overview:
Serial receive front-end for the QAR UART. It synchronises the asynchronous `rx` pin, detects and validates start bits, samples 8N1 frames at mid-bit, and delivers each byte over a valid/ready handshake to the UART RX FIFO write side. It reports framing errors and overruns as single-cycle pulses for the UART status and IRQ logic. Bit timing matches the transmitter: one bit period is `baud_div`+1 clocks.

Parameters:
- `SYNC_STAGES`, 2, number of flops in the `rx` input synchroniser (minimum 2).

Ports:
- `clk`  input  1  system clock
- `rst_n`  input  1  asynchronous active-low reset
- `rx`  input  1  asynchronous serial input, idle high
- `enable`  input  1  receiver enable (UART ctrl bit)
- `baud_div`  input  32  bit period minus one, in clocks; shared with TX
- `data_out`  output  8  received byte, stable while `data_valid`
- `data_valid`  output  1  byte available
- `data_ready`  input  1  consumer accepts byte this cycle
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `overrun`  output  1  one-cycle pulse: completed byte dropped, output still occupied
- `busy`  output  1  high whenever state != IDLE

Behaviour:
- Reset values (asynchronous): sync chain all 1, `rx_prev`=1, state IDLE, counter 0, bit index 0, `data_out`=0x00, `data_valid`/`frame_err`/`overrun`/`busy`=0.
- Synchroniser: `rx_s` is the last flop of the chain. Pin-to-`rx_s` latency is `SYNC_STAGES` cycles. `rx_prev` registers `rx_s`.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- Counter rule: 32-bit cycle counter. A "bit tick" occurs when counter >= `baud_div`; on a tick the counter clears, otherwise it increments. Because the compare is >=, reducing `baud_div` mid-frame can never hang the receiver.
- IDLE: when `enable` && `rx_prev`==1 && `rx_s`==0, go to START with counter=0.
- START: when counter >= (`baud_div`>>1):
  - `rx_s`==0: go to DATA, counter=0, bit index=0.
  - `rx_s`==1: treat as a glitch; return to IDLE silently.
- DATA: on each bit tick, write `rx_s` into shift[bit index] (LSB first) and increment the index. After the 8th sample, go to STOP.
- STOP: on a bit tick, sample `rx_s`:
  - 1: deliver the byte, go to IDLE.
  - 0: pulse `frame_err` for one cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`==1, then go to IDLE. A held-low line (break) produces exactly one `frame_err`.
- Delivery: if !`data_valid` || `data_ready` in the delivery cycle, load `data_out`=shift and set `data_valid`=1. Otherwise pulse `overrun` for one cycle; the old byte is kept and the new byte is lost.
- Handshake: `data_valid` && `data_ready` with no delivery in the same cycle clears `data_valid` at the next edge. A simultaneous accept and delivery leaves `data_valid`=1 with the new byte. `data_out` changes only on delivery.
- `enable` low: state forced to IDLE at the next edge and any frame in flight is aborted with no pulses. `data_valid` and `data_out` are unaffected.
- Supported range is `baud_div` >= 3. Below that, frame contents are unspecified, but the receiver must still return to IDLE.
- Reset asserted mid-frame: immediate return to reset values. Partial data is never delivered.

Test Plan:
All cases use `baud_div`=7 (8 clocks per bit) and `enable`=1 unless noted.
1. Frame 0xA5, `data_ready`=0 → `data_out`=0xA5, `data_valid` rises 76–80 cycles after the `rx` falling edge and stays high. One `data_ready` cycle → `data_valid` drops next cycle; `frame_err`=`overrun`=0 throughout.
2. `rx` pulsed low for 2 clocks, then high → no `data_valid`; `busy` high for at most 6 cycles, then 0.
3. `rx` held low for 12 bit periods, then a valid 0x3C frame → exactly one `frame_err` pulse and no delivery for the break; 0x3C then delivered correctly.
4. Frames 0x11 then 0x22 back-to-back with `data_ready`=0 → `data_out` stays 0x11 and one `overrun` pulse at the second stop sample. `data_ready` for one cycle → `data_valid`=0.
5. `data_ready` tied 1, frames 0x55 then 0xFF with no idle gap → two deliveries in order, no `overrun`/`frame_err`.
6. `rst_n` pulsed low during data bit 4 of a frame → all outputs 0 immediately. The following 0x81 frame is delivered correctly; `enable` dropped mid-frame in a repeat run → no delivery, `busy`=0 next cycle.
